// File: rtl/thread_address_offset.sv
// Per-thread address offset stage: a round-robin thread counter selects an offset
// that is added to the raw operand address, and the result is registered for the range decoders.
module thread_address_offset #(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned THREAD_COUNT = 8,
   parameter int unsigned THREAD_COUNT_WIDTH = 3,
   parameter logic [ADDR_WIDTH-1:0] OFFSET_INIT = '0
) (
   input  logic                          clock,
   input  logic                          clear,
   input  logic [ADDR_WIDTH-1:0]         in_addr,
   input  logic                          in_valid,
   input  logic                          offset_wren,
   input  logic [THREAD_COUNT_WIDTH-1:0] offset_thread,
   input  logic [ADDR_WIDTH-1:0]         offset_data,
   output logic [ADDR_WIDTH-1:0]         out_addr,
   output logic                          out_valid,
   output logic [THREAD_COUNT_WIDTH-1:0] out_thread
);

   localparam logic [THREAD_COUNT_WIDTH-1:0] LAST_THREAD = THREAD_COUNT_WIDTH'(THREAD_COUNT - 1);

   logic [THREAD_COUNT_WIDTH-1:0] thread_cnt;
   logic [ADDR_WIDTH-1:0]         offsets [THREAD_COUNT];
   logic [ADDR_WIDTH-1:0]         sum_c;
   logic                          write_ok_c;

   // Carry out of the add is intentionally dropped; addresses wrap modulo 2^ADDR_WIDTH.
   assign sum_c      = in_addr + offsets[thread_cnt];
   assign write_ok_c = offset_wren && (32'(offset_thread) < THREAD_COUNT);

   always_ff @(posedge clock) begin
      if (clear) begin
         thread_cnt <= '0;
         out_addr   <= '0;
         out_valid  <= 1'b0;
         out_thread <= '0;
         for (int i = 0; i < int'(THREAD_COUNT); i++) begin
            offsets[i] <= OFFSET_INIT;
         end
      end else begin
         thread_cnt <= (thread_cnt == LAST_THREAD) ? '0 : thread_cnt + 1'b1;
         out_addr   <= sum_c;
         out_valid  <= in_valid;
         out_thread <= thread_cnt;
         // Read above uses the pre-write value, so a write lands on the thread's next turn.
         if (write_ok_c) begin
            offsets[offset_thread] <= offset_data;
         end
      end
   end

endmodule

// File: tb/tb_thread_address_offset.sv
// Scoreboard bench for thread_address_offset: an 8-thread instance driven against a
// reference model, plus a 6-thread instance for non-power-of-two wrap and bad-index writes.
module tb_thread_address_offset;

   typedef struct {
      logic [9:0] addr;
      logic       valid;
      logic [2:0] thread;
   } exp_t;

   logic       clock;
   logic       clear;
   logic [9:0] in_addr;
   logic       in_valid;
   logic       offset_wren;
   logic [2:0] offset_thread;
   logic [9:0] offset_data;
   logic [9:0] out_addr;
   logic       out_valid;
   logic [2:0] out_thread;

   logic       clear6;
   logic [9:0] in_addr6;
   logic       in_valid6;
   logic       offset_wren6;
   logic [2:0] offset_thread6;
   logic [9:0] offset_data6;
   logic [9:0] out_addr6;
   logic       out_valid6;
   logic [2:0] out_thread6;

   exp_t       sb[$];
   exp_t       sb6[$];
   int         m_cnt;
   logic [9:0] m_off [8];
   int         n_cmp;
   int         n_fail;

   thread_address_offset #(
      .ADDR_WIDTH(10), .THREAD_COUNT(8), .THREAD_COUNT_WIDTH(3), .OFFSET_INIT(10'h000)
   ) dut (
      .clock(clock), .clear(clear), .in_addr(in_addr), .in_valid(in_valid),
      .offset_wren(offset_wren), .offset_thread(offset_thread), .offset_data(offset_data),
      .out_addr(out_addr), .out_valid(out_valid), .out_thread(out_thread)
   );

   thread_address_offset #(
      .ADDR_WIDTH(10), .THREAD_COUNT(6), .THREAD_COUNT_WIDTH(3), .OFFSET_INIT(10'h000)
   ) dut6 (
      .clock(clock), .clear(clear6), .in_addr(in_addr6), .in_valid(in_valid6),
      .offset_wren(offset_wren6), .offset_thread(offset_thread6), .offset_data(offset_data6),
      .out_addr(out_addr6), .out_valid(out_valid6), .out_thread(out_thread6)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Drive one cycle on the 8-thread instance, record the expected output, advance the model.
   task automatic step(input logic clr, input logic [9:0] a, input logic v,
                       input logic we, input logic [2:0] wt, input logic [9:0] wd);
      exp_t e;
      clear = clr; in_addr = a; in_valid = v;
      offset_wren = we; offset_thread = wt; offset_data = wd;
      if (clr) begin
         e.addr = 10'h000; e.valid = 1'b0; e.thread = 3'd0;
      end else begin
         e.addr = 10'(a + m_off[m_cnt]); e.valid = v; e.thread = 3'(m_cnt);
      end
      sb.push_back(e);
      if (clr) begin
         m_cnt = 0;
         for (int i = 0; i < 8; i++) m_off[i] = 10'h000;
      end else begin
         if (we) m_off[wt] = wd;
         m_cnt = (m_cnt == 7) ? 0 : m_cnt + 1;
      end
      @(posedge clock); #1;
   endtask

   task automatic test_reset();
      exp_t e;
      for (int i = 0; i < 2; i++) begin
         step(1'b1, 10'h3FF, 1'b1, 1'b0, 3'd0, 10'h000);
         e = sb.pop_front();
         n_cmp++;
         if (out_addr !== e.addr || out_valid !== e.valid || out_thread !== e.thread) begin
            n_fail++;
            $display("FAIL reset[%0d]: got addr=%h v=%b t=%0d want addr=%h v=%b t=%0d",
                     i, out_addr, out_valid, out_thread, e.addr, e.valid, e.thread);
         end
      end
      for (int i = 0; i < 9; i++) begin
         step(1'b0, 10'h000, 1'b0, 1'b0, 3'd0, 10'h000);
         e = sb.pop_front();
         n_cmp++;
         if (out_thread !== 3'(i % 8) || out_valid !== 1'b0 || out_addr !== e.addr) begin
            n_fail++;
            $display("FAIL thread_seq[%0d]: got addr=%h v=%b t=%0d want addr=%h v=0 t=%0d",
                     i, out_addr, out_valid, out_thread, e.addr, i % 8);
         end
      end
   endtask

   task automatic test_passthrough();
      exp_t e;
      logic [9:0] a;
      for (int i = 0; i < 10; i++) begin
         a = (i == 0) ? 10'h155 : 10'($urandom_range(0, 1023));
         step(1'b0, a, 1'b1, 1'b0, 3'd0, 10'h000);
         e = sb.pop_front();
         n_cmp++;
         if (out_addr !== a || out_valid !== 1'b1 || out_thread !== e.thread) begin
            n_fail++;
            $display("FAIL passthrough[%0d]: got addr=%h v=%b t=%0d want addr=%h v=1 t=%0d",
                     i, out_addr, out_valid, out_thread, a, e.thread);
         end
      end
   endtask

   task automatic test_offset_write();
      exp_t e;
      step(1'b0, 10'h000, 1'b0, 1'b1, 3'd3, 10'h100);
      void'(sb.pop_front());
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 10'h020, 1'b1, 1'b0, 3'd0, 10'h000);
         e = sb.pop_front();
         n_cmp++;
         if (out_addr !== ((e.thread == 3'd3) ? 10'h120 : 10'h020) ||
             out_valid !== 1'b1 || out_thread !== e.thread) begin
            n_fail++;
            $display("FAIL offset_write[%0d]: got addr=%h t=%0d want addr=%h t=%0d",
                     i, out_addr, out_thread, (e.thread == 3'd3) ? 10'h120 : 10'h020, e.thread);
         end
      end
   endtask

   task automatic test_wrap_rbw();
      exp_t e;
      step(1'b0, 10'h000, 1'b0, 1'b1, 3'd5, 10'h3F0);
      void'(sb.pop_front());
      while (m_cnt != 5) begin
         step(1'b0, 10'h000, 1'b0, 1'b0, 3'd0, 10'h000);
         void'(sb.pop_front());
      end
      // Overwrite thread 5 in the same cycle it translates: old 0x3F0 must apply.
      step(1'b0, 10'h020, 1'b1, 1'b1, 3'd5, 10'h001);
      e = sb.pop_front();
      n_cmp++;
      if (out_addr !== 10'h010 || out_thread !== 3'd5 || out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL wrap_rbw: got addr=%h t=%0d v=%b want addr=010 t=5 v=1",
                  out_addr, out_thread, out_valid);
      end
      while (m_cnt != 5) begin
         step(1'b0, 10'h000, 1'b0, 1'b0, 3'd0, 10'h000);
         void'(sb.pop_front());
      end
      step(1'b0, 10'h020, 1'b1, 1'b0, 3'd0, 10'h000);
      e = sb.pop_front();
      n_cmp++;
      if (out_addr !== 10'h021 || out_thread !== 3'd5) begin
         n_fail++;
         $display("FAIL new_offset: got addr=%h t=%0d want addr=021 t=5", out_addr, out_thread);
      end
   endtask

   task automatic test_clear_mid();
      exp_t e;
      step(1'b0, 10'h000, 1'b0, 1'b1, 3'd2, 10'h0AA);
      void'(sb.pop_front());
      step(1'b1, 10'h123, 1'b1, 1'b1, 3'd2, 10'h2AA);
      e = sb.pop_front();
      n_cmp++;
      if (out_valid !== 1'b0 || out_addr !== 10'h000 || out_thread !== 3'd0) begin
         n_fail++;
         $display("FAIL clear_mid: got addr=%h v=%b t=%0d want addr=000 v=0 t=0",
                  out_addr, out_valid, out_thread);
      end
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 10'h044, 1'b1, 1'b0, 3'd0, 10'h000);
         e = sb.pop_front();
         n_cmp++;
         if (out_addr !== 10'h044 || out_thread !== 3'(i) || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL after_clear[%0d]: got addr=%h t=%0d v=%b want addr=044 t=%0d v=1",
                     i, out_addr, out_thread, out_valid, i);
         end
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      for (int i = 0; i < 48; i++) begin
         step(1'b0, 10'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 10'($urandom_range(0, 1023)));
         e = sb.pop_front();
         n_cmp++;
         if (out_addr !== e.addr || out_valid !== e.valid || out_thread !== e.thread) begin
            n_fail++;
            $display("FAIL back_to_back[%0d]: got addr=%h v=%b t=%0d want addr=%h v=%b t=%0d",
                     i, out_addr, out_valid, out_thread, e.addr, e.valid, e.thread);
         end
      end
   endtask

   task automatic test_six_threads();
      exp_t e;
      int   c;
      clear6 = 1'b1; in_valid6 = 1'b0; in_addr6 = 10'h000; offset_wren6 = 1'b0;
      @(posedge clock); #1;
      clear6 = 1'b0;
      c = 0;
      for (int i = 0; i < 14; i++) begin
         // Cycle 7 attempts an out-of-range write; it must leave every offset alone.
         in_addr6 = 10'(i * 16 + 1); in_valid6 = 1'b1;
         offset_wren6 = (i == 7); offset_thread6 = 3'd7; offset_data6 = 10'h3FF;
         e.addr = in_addr6; e.valid = 1'b1; e.thread = 3'(c);
         sb6.push_back(e);
         c = (c == 5) ? 0 : c + 1;
         @(posedge clock); #1;
         e = sb6.pop_front();
         n_cmp++;
         if (out_addr6 !== e.addr || out_valid6 !== 1'b1 || out_thread6 !== e.thread) begin
            n_fail++;
            $display("FAIL six_threads[%0d]: got addr=%h t=%0d v=%b want addr=%h t=%0d v=1",
                     i, out_addr6, out_thread6, out_valid6, e.addr, e.thread);
         end
      end
      offset_wren6 = 1'b0;
   endtask

   initial begin
      n_cmp = 0; n_fail = 0; m_cnt = 0;
      for (int i = 0; i < 8; i++) m_off[i] = 10'h000;
      clear = 1'b1; in_addr = '0; in_valid = 1'b0;
      offset_wren = 1'b0; offset_thread = '0; offset_data = '0;
      clear6 = 1'b1; in_addr6 = '0; in_valid6 = 1'b0;
      offset_wren6 = 1'b0; offset_thread6 = '0; offset_data6 = '0;
      @(posedge clock); #1;
      test_reset();
      test_passthrough();
      test_offset_write();
      test_wrap_rbw();
      test_clear_mid();
      test_back_to_back();
      test_six_threads();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
